// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, interrupt cause codes
// and a helper that builds the 64-bit cause word.
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT,
        ST_WAIT_VEC,
        ST_REDIRECT
    } trap_state_e;

    localparam logic [5:0] IRQ_EXT = 6'd11;
    localparam logic [5:0] IRQ_SW  = 6'd3;
    localparam logic [5:0] IRQ_TMR = 6'd7;

    localparam int IRQ_FLAG_BIT = 63;

    function automatic logic [63:0] make_cause(input logic is_irq, input logic [5:0] code);
        logic [63:0] c;
        c               = '0;
        c[IRQ_FLAG_BIT] = is_irq;
        c[5:0]          = code;
        return c;
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Picks the highest-priority enabled interrupt: external > software > timer.
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic [2:0] irq_pending_i,
    input  logic       global_ie_i,
    output logic       valid_o,
    output logic [5:0] code_o
);

    always_comb begin
        valid_o = global_ie_i && (|irq_pending_i);
        code_o  = IRQ_TMR;
        if (irq_pending_i[2]) begin
            code_o = IRQ_EXT;
        end else if (irq_pending_i[1]) begin
            code_o = IRQ_SW;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: takes an exception or interrupt, drains the pipeline, pulses the CSR
// commit, captures the returned vector and issues a one-cycle fetch redirect.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [1:0] TRAP_PRIV = 2'b11,
    parameter int         DRAIN_MAX = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exc_valid_i,
    input  logic [5:0]  exc_code_i,
    input  logic [63:0] exc_pc_i,
    input  logic [2:0]  irq_pending_i,
    input  logic        global_ie_i,
    input  logic [63:0] retire_pc_i,
    input  logic [1:0]  cur_priv_i,
    input  logic        pipe_empty_i,
    input  logic [63:0] vec_in_i,
    output logic        flush_o,
    output logic        cs_o,
    output logic [63:0] cause_o,
    output logic [3:0]  privilege_o,
    output logic [63:0] npc_o,
    output logic        redirect_valid_o,
    output logic [63:0] redirect_pc_o,
    output logic        busy_o,
    output logic        drain_timeout_o
);

    localparam int CNT_W = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);

    trap_state_e  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic         flush_q, cs_q, redir_valid_q, busy_q, timeout_q;
    logic [63:0]  cause_q, npc_q, redir_pc_q;
    logic [3:0]   priv_q;

    logic         irq_valid;
    logic [5:0]   irq_code;
    logic         drain_done_d;

    trap_prio_enc u_prio (
        .irq_pending_i (irq_pending_i),
        .global_ie_i   (global_ie_i),
        .valid_o       (irq_valid),
        .code_o        (irq_code)
    );

    assign drain_done_d = pipe_empty_i || (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            flush_q       <= 1'b0;
            cs_q          <= 1'b0;
            redir_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cause_q       <= '0;
            npc_q         <= '0;
            redir_pc_q    <= '0;
            priv_q        <= '0;
        end else begin
            cs_q          <= 1'b0;
            redir_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // exception wins over any interrupt sampled in the same cycle
                    if (exc_valid_i || irq_valid) begin
                        cause_q <= exc_valid_i ? make_cause(1'b0, exc_code_i)
                                               : make_cause(1'b1, irq_code);
                        npc_q   <= exc_valid_i ? exc_pc_i : retire_pc_i;
                        priv_q  <= {TRAP_PRIV, cur_priv_i};
                        cnt_q   <= '0;
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (drain_done_d) begin
                        cs_q    <= 1'b1;
                        state_q <= ST_COMMIT;
                        if (!pipe_empty_i) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_WAIT_VEC;
                end
                ST_WAIT_VEC: begin
                    redir_pc_q    <= vec_in_i;
                    redir_valid_q <= 1'b1;
                    state_q       <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign flush_o          = flush_q;
    assign cs_o             = cs_q;
    assign cause_o          = cause_q;
    assign privilege_o      = priv_q;
    assign npc_o            = npc_q;
    assign redirect_valid_o = redir_valid_q;
    assign redirect_pc_o    = redir_pc_q;
    assign busy_o           = busy_q;
    assign drain_timeout_o  = timeout_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a table of single-trap vectors plus hand sequences for
// drain delay, drain timeout, reset during commit and busy lockout.
module tb_trap_ctrl;

    logic        clk, rst;
    logic        exc_valid;
    logic [5:0]  exc_code;
    logic [63:0] exc_pc;
    logic [2:0]  irq_pending;
    logic        global_ie;
    logic [63:0] retire_pc;
    logic [1:0]  cur_priv;
    logic        pipe_empty;
    logic [63:0] vec_in;
    logic        flush, cs, redirect_valid, busy, drain_timeout;
    logic [63:0] cause, npc, redirect_pc;
    logic [3:0]  privilege;

    int tests = 0;
    int fails = 0;

    trap_ctrl #(.TRAP_PRIV(2'b11), .DRAIN_MAX(16)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .exc_valid_i      (exc_valid),
        .exc_code_i       (exc_code),
        .exc_pc_i         (exc_pc),
        .irq_pending_i    (irq_pending),
        .global_ie_i      (global_ie),
        .retire_pc_i      (retire_pc),
        .cur_priv_i       (cur_priv),
        .pipe_empty_i     (pipe_empty),
        .vec_in_i         (vec_in),
        .flush_o          (flush),
        .cs_o             (cs),
        .cause_o          (cause),
        .privilege_o      (privilege),
        .npc_o            (npc),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .busy_o           (busy),
        .drain_timeout_o  (drain_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        exc;
        logic [5:0]  code;
        logic [63:0] epc;
        logic [2:0]  irq;
        logic        gie;
        logic [63:0] rpc;
        logic [1:0]  priv;
        logic [63:0] vec;
        logic        trap;
        logic [63:0] exp_cause;
        logic [63:0] exp_npc;
        logic [3:0]  exp_priv;
    } vec_t;

    vec_t vt[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Applies one table entry at cycle 0 and checks the full trap timeline (or absence of one).
    task automatic run_vec(input vec_t v, input int idx);
        int any_busy;
        any_busy    = 0;
        exc_valid   = v.exc;
        exc_code    = v.code;
        exc_pc      = v.epc;
        irq_pending = v.irq;
        global_ie   = v.gie;
        retire_pc   = v.rpc;
        cur_priv    = v.priv;
        pipe_empty  = 1'b1;
        vec_in      = v.vec;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (busy === 1'b1) any_busy++;
            if (v.trap) begin
                if (c == 1) begin
                    chk($sformatf("v%0d busy c1", idx), busy, 1);
                    chk($sformatf("v%0d flush c1", idx), flush, 1);
                end
                if (c == 2) begin
                    chk($sformatf("v%0d cs c2", idx), cs, 1);
                    chk($sformatf("v%0d cause", idx), cause, v.exp_cause);
                    chk($sformatf("v%0d npc", idx), npc, v.exp_npc);
                    chk($sformatf("v%0d priv", idx), privilege, v.exp_priv);
                end
                if (c == 3) chk($sformatf("v%0d cs c3", idx), cs, 0);
                if (c == 4) begin
                    chk($sformatf("v%0d redirect_valid c4", idx), redirect_valid, 1);
                    chk($sformatf("v%0d redirect_pc", idx), redirect_pc, v.vec);
                    chk($sformatf("v%0d flush c4", idx), flush, 1);
                end
                if (c == 5) begin
                    chk($sformatf("v%0d busy c5", idx), busy, 0);
                    chk($sformatf("v%0d flush c5", idx), flush, 0);
                    chk($sformatf("v%0d redirect_valid c5", idx), redirect_valid, 0);
                end
            end
            if (c == 1) begin
                exc_valid   = 1'b0;
                irq_pending = 3'b000;
            end
        end
        if (!v.trap) chk($sformatf("v%0d no busy", idx), any_busy, 0);
    endtask

    initial begin
        int first_cs, first_rv, first_to, n_cs, any_act;
        int cs_cyc[2];
        logic [63:0] cs_cause[2];
        logic [63:0] cs_npc[2];

        vt[0] = '{1'b1, 6'd2,  64'h1000, 3'b000, 1'b0, 64'h0,    2'd0, 64'h8000, 1'b1,
                  64'h2, 64'h1000, 4'b1100};
        vt[1] = '{1'b0, 6'd0,  64'h0,    3'b111, 1'b1, 64'h2004, 2'd3, 64'h9000, 1'b1,
                  64'h8000_0000_0000_000B, 64'h2004, 4'b1111};
        vt[2] = '{1'b0, 6'd0,  64'h0,    3'b010, 1'b1, 64'h3000, 2'd1, 64'hA000, 1'b1,
                  64'h8000_0000_0000_0003, 64'h3000, 4'b1101};
        vt[3] = '{1'b0, 6'd0,  64'h0,    3'b001, 1'b1, 64'h3008, 2'd0, 64'hB000, 1'b1,
                  64'h8000_0000_0000_0007, 64'h3008, 4'b1100};
        vt[4] = '{1'b0, 6'd0,  64'h0,    3'b001, 1'b0, 64'h4000, 2'd0, 64'hC000, 1'b0,
                  64'h0, 64'h0, 4'b0000};
        vt[5] = '{1'b1, 6'd5,  64'h5000, 3'b001, 1'b1, 64'h5004, 2'd2, 64'hD000, 1'b1,
                  64'h5, 64'h5000, 4'b1110};
        vt[6] = '{1'b0, 6'd0,  64'h0,    3'b000, 1'b1, 64'h6000, 2'd0, 64'hE000, 1'b0,
                  64'h0, 64'h0, 4'b0000};
        vt[7] = '{1'b1, 6'd63, 64'hFFFF_FFFF_FFFF_FFFC, 3'b110, 1'b1, 64'h7000, 2'd2,
                  64'hFFFF_0000_0000_0100, 1'b1, 64'h3F, 64'hFFFF_FFFF_FFFF_FFFC, 4'b1110};

        rst = 1'b1;
        exc_valid = 0; exc_code = 0; exc_pc = 0; irq_pending = 0; global_ie = 0;
        retire_pc = 0; cur_priv = 0; pipe_empty = 1; vec_in = 0;
        #3;
        chk("reset cs", cs, 0);
        chk("reset flush", flush, 0);
        chk("reset busy", busy, 0);
        chk("reset redirect_valid", redirect_valid, 0);
        chk("reset cause", cause, 0);
        chk("reset npc", npc, 0);
        chk("reset priv", privilege, 0);
        chk("reset timeout", drain_timeout, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // pipeline empties during cycle 3: commit at cycle 4, redirect at cycle 6
        exc_valid = 1; exc_code = 6'd4; exc_pc = 64'h40; cur_priv = 0;
        pipe_empty = 0; vec_in = 64'h4400;
        first_cs = -1; first_rv = -1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (cs === 1'b1 && first_cs < 0) first_cs = c;
            if (redirect_valid === 1'b1 && first_rv < 0) first_rv = c;
            if (c == 1) exc_valid = 0;
            if (c == 3) pipe_empty = 1;
        end
        chk("slow drain cs cycle", first_cs, 4);
        chk("slow drain redirect cycle", first_rv, 6);
        chk("slow drain no timeout", drain_timeout, 0);

        // pipeline never empties: commit forced at DRAIN_MAX+1
        exc_valid = 1; exc_code = 6'd1; exc_pc = 64'h80; pipe_empty = 0; vec_in = 64'h8800;
        first_cs = -1; first_to = -1; first_rv = -1; n_cs = 0;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (cs === 1'b1) begin
                n_cs++;
                if (first_cs < 0) first_cs = c;
            end
            if (drain_timeout === 1'b1 && first_to < 0) first_to = c;
            if (redirect_valid === 1'b1 && first_rv < 0) first_rv = c;
            if (c == 1) exc_valid = 0;
        end
        chk("timeout cs cycle", first_cs, 17);
        chk("timeout cs count", n_cs, 1);
        chk("timeout flag cycle", first_to, 17);
        chk("timeout redirect cycle", first_rv, 19);
        run_vec(vt[0], 100);
        chk("timeout sticky", drain_timeout, 1);

        // reset asserted while CS is high
        exc_valid = 1; exc_code = 6'd2; exc_pc = 64'h1000; pipe_empty = 1; vec_in = 64'h8000;
        step();
        exc_valid = 0;
        step();
        chk("pre-reset cs", cs, 1);
        rst = 1'b1;
        #1;
        chk("mid reset cs", cs, 0);
        chk("mid reset flush", flush, 0);
        chk("mid reset busy", busy, 0);
        chk("mid reset timeout", drain_timeout, 0);
        @(negedge clk);
        rst = 1'b0;
        any_act = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (redirect_valid === 1'b1 || busy === 1'b1) any_act++;
        end
        chk("post reset quiet", any_act, 0);
        run_vec(vt[0], 101);

        // busy lockout: exception during DRAIN ignored, held timer irq taken at cycle 5
        exc_valid = 1; exc_code = 6'd2; exc_pc = 64'h500; cur_priv = 0;
        global_ie = 1; irq_pending = 0; retire_pc = 64'h600; pipe_empty = 1; vec_in = 64'h7700;
        n_cs = 0;
        cs_cyc[0] = -1; cs_cyc[1] = -1;
        cs_cause[0] = '0; cs_cause[1] = '0; cs_npc[0] = '0; cs_npc[1] = '0;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (cs === 1'b1) begin
                if (n_cs < 2) begin
                    cs_cyc[n_cs]   = c;
                    cs_cause[n_cs] = cause;
                    cs_npc[n_cs]   = npc;
                end
                n_cs++;
            end
            if (c == 1) begin
                exc_code = 6'd9; exc_pc = 64'h900; irq_pending = 3'b001;
            end
            if (c == 2) exc_valid = 0;
            if (c == 6) irq_pending = 3'b000;
        end
        chk("lockout cs count", n_cs, 2);
        chk("lockout cs1 cycle", cs_cyc[0], 2);
        chk("lockout cs1 cause", cs_cause[0], 64'h2);
        chk("lockout cs1 npc", cs_npc[0], 64'h500);
        chk("lockout cs2 cycle", cs_cyc[1], 7);
        chk("lockout cs2 cause", cs_cause[1], 64'h8000_0000_0000_0007);
        chk("lockout cs2 npc", cs_npc[1], 64'h600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer sitting directly upstream of the CSR file. It arbitrates synchronous exceptions and pending interrupts, drains the pipeline, then issues the single-cycle `CS` trap commit with `CAUSE`, `PRIVILEGE` and `NPC`. It captures the vector address the CSR file returns on `VEC_OUT` and issues a one-cycle PC redirect to fetch.

## Interface
- `TRAP_PRIV`, default 2'b11: privilege mode entered on a trap (machine).
- `DRAIN_MAX`, default 16: maximum number of cycles to wait for `PIPE_EMPTY` before committing anyway.
- `CLK` in 1: single clock. All state changes on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `EXC_VALID` in 1: synchronous exception reported by execute.
- `EXC_CODE` in 6: exception cause code.
- `EXC_PC` in 64: PC of the faulting instruction.
- `IRQ_PENDING` in 3: {external, software, timer} requests, already masked by xie.
- `GLOBAL_IE` in 1: current xstatus.xie.
- `RETIRE_PC` in 64: next PC after the last retired instruction.
- `CUR_PRIV` in 2: current privilege mode.
- `PIPE_EMPTY` in 1: pipeline fully drained.
- `VEC_IN` in 64: `VEC_OUT` from the CSR file.
- `FLUSH` out 1: kill and stall the pipeline.
- `CS` out 1: trap commit pulse to the CSR file.
- `CAUSE` out 64: bit 63 is the interrupt flag; bits [5:0] carry the code; all other bits are zero.
- `PRIVILEGE` out 4: {new = `TRAP_PRIV`, old = latched `CUR_PRIV`}.
- `NPC` out 64: saved return PC.
- `REDIRECT_VALID` out 1: one-cycle fetch redirect.
- `REDIRECT_PC` out 64: trap handler address.
- `BUSY` out 1: FSM is not in IDLE.
- `DRAIN_TIMEOUT` out 1: sticky flag, cleared only by `RESET`.

## Operation
The FSM has five states: IDLE, DRAIN, COMMIT, WAIT_VEC, REDIRECT. All outputs are registered. On reset every output is 0, the state is IDLE and the drain counter is 0.

**IDLE**
- If `EXC_VALID` is high, latch the exception:
  - `CAUSE` = {0, `EXC_CODE`}
  - `NPC` = `EXC_PC`
  - go to DRAIN.
- Otherwise, if `GLOBAL_IE` is high and `IRQ_PENDING` is non-zero, latch the highest-priority interrupt:
  - priority is external (code 11) > software (3) > timer (7)
  - `CAUSE` = {1, code}
  - `NPC` = `RETIRE_PC`
  - go to DRAIN.
- In both cases, latch `CUR_PRIV` into `PRIVILEGE[1:0]`.
- An exception always beats an interrupt arriving in the same cycle.

**DRAIN**
- `FLUSH` is high. The counter increments each cycle.
- Go to COMMIT when `PIPE_EMPTY` is high or the counter reaches `DRAIN_MAX`-1.
- On the timeout path, also set `DRAIN_TIMEOUT`.

**COMMIT**
- `CS` is high for exactly this one cycle.
- `CAUSE`, `PRIVILEGE` and `NPC` are stable from DRAIN entry through REDIRECT.

**WAIT_VEC**
- The CSR file registered `VEC_OUT` at the COMMIT edge, so `VEC_IN` is valid here.
- Capture `VEC_IN` into `REDIRECT_PC`.

**REDIRECT**
- `REDIRECT_VALID` is high for one cycle.
- `FLUSH` is still high in this cycle. Go to IDLE, where `FLUSH` drops.

**Events and reset**
- `EXC_VALID` and `IRQ_PENDING` are ignored outside IDLE.
- Interrupts are level-sensitive. A request that is still pending is re-evaluated on return to IDLE.
- Reset mid-sequence aborts immediately: state goes to IDLE and all outputs go to 0, including a `CS` pulse in flight.

## Timing
- Event sampled in IDLE at cycle 0.
- `FLUSH` and `BUSY` go high at cycle 1.
- With `PIPE_EMPTY` already high: `CS` at cycle 2, `REDIRECT_VALID` at cycle 4, back in IDLE at cycle 5.
- Each extra drain cycle delays `CS` and the redirect by one cycle.
- Worst-case drain: `CS` at cycle `DRAIN_MAX`+1.
- Minimum gap between two traps: 5 cycles, since the next event is sampled in IDLE at cycle 5.
- Counter width is clog2(`DRAIN_MAX`). It resets to 0 on every DRAIN entry.

## Structure
- Shared package `trap_pkg` holds:
  - the state enum
  - cause-code constants (`IRQ_EXT`=11, `IRQ_SW`=3, `IRQ_TMR`=7)
  - the interrupt flag bit position, 63.
- Sub-module `trap_prio_enc` is combinational. Inputs: `IRQ_PENDING` and `GLOBAL_IE`. Outputs: a valid flag and a 6-bit code.
- Everything else lives in one FSM module.

## Test plan
- **Exception:** `EXC_VALID`=1, `EXC_CODE`=2, `EXC_PC`=0x1000, `CUR_PRIV`=0, `PIPE_EMPTY`=1. Expect:
  - `CS` at cycle 2 with `CAUSE`=0x2, `NPC`=0x1000, `PRIVILEGE`=4'b1100
  - `VEC_IN`=0x8000 at cycle 3, then `REDIRECT_PC`=0x8000 and `REDIRECT_VALID` at cycle 4.
- **Interrupt priority:** `IRQ_PENDING`=3'b111, `GLOBAL_IE`=1, `RETIRE_PC`=0x2004. Expect `CAUSE`=0x800000000000000B and `NPC`=0x2004.
- **Masking and simultaneity:**
  - `GLOBAL_IE`=0 with `IRQ_PENDING`=3'b001 gives no `BUSY`, ever.
  - `EXC_VALID` in the same cycle as a timer interrupt gives the exception cause.
- **Drain timeout:** `PIPE_EMPTY` held at 0 with `DRAIN_MAX`=16. Expect `CS` at cycle 17 and `DRAIN_TIMEOUT` going high and staying high.
- **Reset mid-sequence:** assert `RESET` during COMMIT. Expect:
  - `CS`, `FLUSH` and `BUSY` all 0 immediately
  - no `REDIRECT_VALID`
  - a fresh exception after release completes normally.
- **Busy lockout:** a second `EXC_VALID` during DRAIN is ignored. A timer interrupt still pending at cycle 5 starts a new trap.
